adc_seq_reader: RTL and testbench
=================================

Name: adc_seq_reader

Overview:
Host-side initiator for the SAR ADC conversion handshake. It issues nStartCnv requests, either periodically or as a one-shot. It tracks nEndCnv through the busy and done phases and captures the ADC's 8-bit result. Samples are buffered in a small FIFO for downstream logic, with timeout and overflow detection.

Parameters:
GAP_CYCLES, 8, idle cycles between a capture and the next start in continuous mode (0 allowed)
TIMEOUT, 64, maximum cycles allowed in START or in BUSY before an error is declared
FIFO_DEPTH, 8, sample FIFO entries; power of two, minimum 2

Ports:
clock  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-low reset
enable  in  1  continuous mode: start a new conversion after each gap while high
single  in  1  one-cycle pulse; requests one conversion when in IDLE
nEndCnv  in  1  ADC status: 1 = converting, 0 = idle/done
adcData  in  8  ADC result bus (the ADC's dataOut)
nStartCnv  out  1  ADC start request, active-low
rd_en  in  1  FIFO pop request
rd_data  out  8  FIFO head; valid when fifo_empty=0
fifo_empty  out  1  FIFO empty flag
fifo_full  out  1  FIFO full flag
overflow  out  1  sticky: a sample was dropped because the FIFO was full
timeout_err  out  1  sticky: a handshake phase exceeded TIMEOUT
clear_err  in  1  clears overflow and timeout_err
busy  out  1  high in any state other than IDLE
sample_cnt  out  16  accepted-sample counter; wraps at 0xFFFF

Behaviour:
- Reset (reset==0 at a clock edge):
  - nStartCnv=1, busy=0, overflow=0, timeout_err=0, sample_cnt=0.
  - FIFO pointers cleared, so fifo_empty=1, fifo_full=0, rd_data=0.
  - State goes to IDLE and the timeout and gap counters go to 0.
  - Reset asserted mid-conversion abandons the conversion. nStartCnv returns high on the next edge.
- States: IDLE, START, BUSY, CAPTURE, GAP.
- IDLE:
  - nStartCnv=1.
  - If enable==1 or single==1, go to START. Single and enable together count as one request.
- START:
  - nStartCnv=0; the timeout counter increments each cycle.
  - When nEndCnv==1 is sampled, go to BUSY. nStartCnv is registered to 1 in that same transition.
  - Purpose: releasing nStartCnv here prevents the ADC from re-triggering back-to-back.
- BUSY:
  - nStartCnv=1; wait for nEndCnv==0, then go to CAPTURE.
  - The timeout counter restarts at 0 on entry to BUSY.
- CAPTURE (one cycle):
  - Register adcData into the FIFO. The ADC updates dataOut one cycle before nEndCnv falls, so adcData is stable here.
  - If a write is accepted, sample_cnt increments.
  - If the FIFO is full and rd_en==0, the sample is dropped and overflow is set.
  - If the FIFO is full and rd_en==1 in the same cycle, both the read and the write proceed and the FIFO stays full.
  - Then go to GAP if enable==1, else to IDLE.
- GAP:
  - Counts GAP_CYCLES cycles, then goes to START if enable==1, else to IDLE.
  - With GAP_CYCLES=0, the FSM passes through GAP for exactly one cycle.
  - Deasserting enable during GAP returns the FSM to IDLE on the next edge.
- Enable deasserted during START or BUSY: the current conversion completes and captures, then the FSM goes to IDLE.
- Timeout: if the counter reaches TIMEOUT in START or BUSY:
  - timeout_err is set, nStartCnv is set to 1, state goes to IDLE, and nothing is written.
- Sticky flags:
  - clear_err has priority over a set in the same cycle only if no new event occurs that cycle. A simultaneous new event leaves the flag set.
- FIFO:
  - rd_data is the registered head and updates on the edge after a pop.
  - rd_en while empty is ignored: no pointer change, no error.
  - Pointers use one extra wrap bit for full/empty detection.
- single pulses outside IDLE are ignored (no queuing).
- Latency with the standard ADC (29 cycles from start acceptance to done): about 31 cycles per sample, plus GAP_CYCLES.

Decomposition:
- Package adc_seq_pkg holds:
  - the state enum (3-bit encoding);
  - ADC_W=8 and CNT_W=16;
  - the default TIMEOUT and GAP_CYCLES constants.
- Sub-module adc_sample_fifo: synchronous FIFO with parameters WIDTH and DEPTH. Ports: clock, reset, wr_en, wr_data, rd_en, rd_data, empty, full.
- The FSM, counters and sticky flags live in the top level.

Test Plan:
- Reset during BUSY, then hold reset=1 -> nStartCnv=1 and fifo_empty=1 on the next edge; sample_cnt=0; no capture occurs.
- single pulse with the ADC model converting 0xA5 -> nStartCnv low until nEndCnv rises; one FIFO entry; rd_data=0xA5 after a pop; sample_cnt=1; busy returns to 0.
- enable=1, GAP_CYCLES=8, FIFO_DEPTH=8, no reads, ADC values 0x00..0x0A -> first 8 stored in order; sample 9 dropped and overflow=1; fifo_full=1; sample_cnt=8.
- FIFO full, with rd_en=1 in the CAPTURE cycle -> the oldest entry is popped and the new one written; fifo_full stays 1; overflow stays 0.
- ADC model never raises nEndCnv -> after 64 cycles in START, timeout_err=1, nStartCnv=1, state IDLE; clear_err pulse -> timeout_err=0.
- enable dropped mid-BUSY -> that sample is captured, then IDLE with no further nStartCnv assertion over 100 cycles.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the SAR ADC sequencer.
package adc_seq_pkg;

   localparam int ADC_W          = 8;
   localparam int CNT_W          = 16;
   localparam int DEF_TIMEOUT    = 64;
   localparam int DEF_GAP_CYCLES = 8;
   localparam int DEF_FIFO_DEPTH = 8;

   // Handshake sequencer states
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_BUSY    = 3'd2,
      S_CAPTURE = 3'd3,
      S_GAP     = 3'd4
   } state_t;

   // Counter width able to hold values 0..max_val (never narrower than 1 bit)
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 2);
   endfunction

endpackage

// File: rtl/adc_seq_reader_if.sv
// ADC conversion handshake: start request out, status and result back.
interface adc_seq_reader_if;
   import adc_seq_pkg::*;

   logic             nStartCnv;
   logic             nEndCnv;
   logic [ADC_W-1:0] adcData;

   // Host side drives the start request
   modport master (
      output nStartCnv,
      input  nEndCnv,
      input  adcData
   );

   // ADC side answers with status and data
   modport slave (
      input  nStartCnv,
      output nEndCnv,
      output adcData
   );

endinterface

// File: rtl/adc_seq_reader_fifo.sv
// Synchronous sample FIFO with registered head output and wrap-bit pointers.
module adc_sample_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_rd_data;

   logic             w_empty;
   logic             w_full;
   logic             w_do_wr;
   logic             w_do_rd;
   logic [AW:0]      w_wr_ptr_next;
   logic [AW:0]      w_rd_ptr_next;
   logic             w_empty_next;
   logic [AW-1:0]    w_head_addr;
   logic             w_head_bypass;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A full FIFO still accepts a write when a pop frees a slot in the same cycle
   assign w_do_wr = wr_en && (!w_full || rd_en);
   assign w_do_rd = rd_en && !w_empty;

   assign w_wr_ptr_next = r_wr_ptr + (AW+1)'(w_do_wr);
   assign w_rd_ptr_next = r_rd_ptr + (AW+1)'(w_do_rd);
   assign w_empty_next  = (w_wr_ptr_next == w_rd_ptr_next);

   // Next head location; if it is the slot being written now, forward the write data
   assign w_head_addr   = w_rd_ptr_next[AW-1:0];
   assign w_head_bypass = w_do_wr && (w_head_addr == r_wr_ptr[AW-1:0]);

   // Sample storage write port (no reset, maps onto RAM)
   always_ff @(posedge clock) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Pointer update and registered head read
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rd_data <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_next;
         r_rd_ptr <= w_rd_ptr_next;
         if (!w_empty_next) begin
            r_rd_data <= w_head_bypass ? wr_data : r_mem[w_head_addr];
         end
      end
   end

   assign rd_data = r_rd_data;
   assign empty   = w_empty;
   assign full    = w_full;

endmodule

// File: rtl/adc_seq_reader.sv
// SAR ADC conversion initiator: start/busy/done handshake, sample FIFO,
// timeout and overflow detection, accepted-sample counter.
module adc_seq_reader
   import adc_seq_pkg::*;
#(
   parameter int GAP_CYCLES = DEF_GAP_CYCLES,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              single,
   adc_seq_reader_if.master  adc,
   input  logic              rd_en,
   output logic [ADC_W-1:0]  rd_data,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              overflow,
   output logic              timeout_err,
   input  logic              clear_err,
   output logic              busy,
   output logic [CNT_W-1:0]  sample_cnt
);

   localparam int TO_W  = cnt_width(TIMEOUT);
   localparam int GAP_W = cnt_width(GAP_CYCLES);

   // Last count value before the phase gives up / the gap ends
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [TO_W-1:0]    r_to_cnt;
   logic [TO_W-1:0]    w_to_cnt_next;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic [GAP_W-1:0]   w_gap_cnt_next;
   logic               r_nstart;
   logic               r_overflow;
   logic               r_timeout;
   logic [CNT_W-1:0]   r_sample_cnt;

   logic               w_wr_req;
   logic               w_drop;
   logic               w_wr_accept;
   logic               w_timeout_evt;

   // Next-state, phase counters and capture request
   always_comb begin
      w_state_next   = r_state;
      w_to_cnt_next  = r_to_cnt;
      w_gap_cnt_next = r_gap_cnt;
      w_wr_req       = 1'b0;
      w_timeout_evt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (enable || single) begin
               w_state_next  = S_START;
               w_to_cnt_next = '0;
            end
         end

         S_START: begin
            if (adc.nEndCnv) begin
               w_state_next  = S_BUSY;
               w_to_cnt_next = '0;
            end else if (r_to_cnt == TO_LAST) begin
               w_timeout_evt = 1'b1;
               w_state_next  = S_IDLE;
               w_to_cnt_next = '0;
            end else begin
               w_to_cnt_next = r_to_cnt + TO_W'(1);
            end
         end

         S_BUSY: begin
            if (!adc.nEndCnv) begin
               w_state_next  = S_CAPTURE;
               w_to_cnt_next = '0;
            end else if (r_to_cnt == TO_LAST) begin
               w_timeout_evt = 1'b1;
               w_state_next  = S_IDLE;
               w_to_cnt_next = '0;
            end else begin
               w_to_cnt_next = r_to_cnt + TO_W'(1);
            end
         end

         S_CAPTURE: begin
            w_wr_req = 1'b1;
            if (enable) begin
               w_state_next   = S_GAP;
               w_gap_cnt_next = '0;
            end else begin
               w_state_next = S_IDLE;
            end
         end

         S_GAP: begin
            if (!enable) begin
               w_state_next = S_IDLE;
            end else if (r_gap_cnt == GAP_LAST) begin
               w_state_next  = S_START;
               w_to_cnt_next = '0;
            end else begin
               w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // A capture into a full FIFO is lost unless a pop makes room in the same cycle
   assign w_drop      = w_wr_req && fifo_full && !rd_en;
   assign w_wr_accept = w_wr_req && !w_drop;

   // State and phase counter registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_to_cnt  <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_to_cnt  <= w_to_cnt_next;
         r_gap_cnt <= w_gap_cnt_next;
      end
   end

   // Start request is low only while START is (or becomes) the current state,
   // so it is released on the same edge the ADC's busy status is seen
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_nstart <= 1'b1;
      end else begin
         r_nstart <= (w_state_next != S_START);
      end
   end

   // Sticky error flags: a new event in the same cycle beats clear_err
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_overflow <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clear_err) begin
            r_overflow <= 1'b0;
         end
         if (w_timeout_evt) begin
            r_timeout <= 1'b1;
         end else if (clear_err) begin
            r_timeout <= 1'b0;
         end
      end
   end

   // Accepted-sample counter, wraps naturally
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_sample_cnt <= '0;
      end else if (w_wr_accept) begin
         r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      end
   end

   adc_sample_fifo #(
      .WIDTH (ADC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (w_wr_req),
      .wr_data (adc.adcData),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign adc.nStartCnv = r_nstart;
   assign overflow      = r_overflow;
   assign timeout_err   = r_timeout;
   assign busy          = (r_state != S_IDLE);
   assign sample_cnt    = r_sample_cnt;

endmodule

// File: tb/tb_adc_seq_reader.sv
// Directed bench for adc_seq_reader with a behavioural SAR ADC model.
module tb_adc_seq_reader;
   import adc_seq_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        single;
   logic        rd_en;
   logic        clear_err;
   logic [7:0]  rd_data;
   logic        fifo_empty;
   logic        fifo_full;
   logic        overflow;
   logic        timeout_err;
   logic        busy;
   logic [15:0] sample_cnt;

   int errors = 0;
   int checks = 0;

   // ADC model controls: result = adc_base + conversions since adc_mark
   logic       adc_dead = 1'b0;
   logic [7:0] adc_base = 8'd0;
   logic [7:0] adc_mark = 8'd0;
   logic [7:0] adc_cnt  = 8'd0;

   adc_seq_reader_if adc_if ();

   adc_seq_reader #(
      .GAP_CYCLES (8),
      .TIMEOUT    (64),
      .FIFO_DEPTH (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .single      (single),
      .adc         (adc_if),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .fifo_empty  (fifo_empty),
      .fifo_full   (fifo_full),
      .overflow    (overflow),
      .timeout_err (timeout_err),
      .clear_err   (clear_err),
      .busy        (busy),
      .sample_cnt  (sample_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         $display("check %-20s observed=%0h expected=%0h ok", tag, obs, exp);
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_adc(input logic [7:0] base);
      adc_base = base;
      adc_mark = adc_cnt;
   endtask

   // ADC: raise busy after seeing start low, data valid one cycle before done, 29-cycle conversion
   initial begin
      adc_if.nEndCnv = 1'b0;
      adc_if.adcData = 8'd0;
      forever begin
         @(posedge clock);
         #1;
         if (!adc_dead && adc_if.nStartCnv === 1'b0) begin
            adc_if.nEndCnv = 1'b1;
            repeat (28) @(posedge clock);
            #1 adc_if.adcData = adc_base + (adc_cnt - adc_mark);
            @(posedge clock);
            #1 adc_if.nEndCnv = 1'b0;
            adc_cnt = adc_cnt + 8'd1;
         end
      end
   end

   // Hard stop in case the run stalls
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nlow;
      logic [7:0] exp_drain [8];
      exp_drain = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9};

      reset = 1'b0; enable = 1'b0; single = 1'b0; rd_en = 1'b0; clear_err = 1'b0;
      repeat (3) @(negedge clock);

      // Reset state
      chk("rst_nstart",     adc_if.nStartCnv, 1);
      chk("rst_busy",       busy, 0);
      chk("rst_overflow",   overflow, 0);
      chk("rst_timeout",    timeout_err, 0);
      chk("rst_sample_cnt", sample_cnt, 0);
      chk("rst_empty",      fifo_empty, 1);
      chk("rst_full",       fifo_full, 0);
      chk("rst_rd_data",    rd_data, 0);

      // Reset during BUSY abandons the conversion
      reset = 1'b1;
      @(negedge clock);
      single = 1'b1;
      @(negedge clock);
      single = 1'b0;
      chk("rb_start_low", adc_if.nStartCnv, 0);
      repeat (8) @(negedge clock);
      chk("rb_in_busy", busy, 1);
      chk("rb_busy_nstart", adc_if.nStartCnv, 1);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      chk("rb_nstart", adc_if.nStartCnv, 1);
      chk("rb_idle", busy, 0);
      chk("rb_empty", fifo_empty, 1);
      repeat (40) @(negedge clock);
      chk("rb_no_capture", fifo_empty, 1);
      chk("rb_sample_cnt", sample_cnt, 0);

      // One-shot conversion of 0xA5
      set_adc(8'hA5);
      single = 1'b1;
      @(negedge clock);
      single = 1'b0;
      chk("ss_start_low", adc_if.nStartCnv, 0);
      chk("ss_busy", busy, 1);
      @(negedge clock);
      chk("ss_start_release", adc_if.nStartCnv, 1);
      n = 0;
      while (fifo_empty && n < 60) begin
         @(negedge clock);
         n++;
      end
      chk("ss_latency", n, 30);
      chk("ss_rd_data", rd_data, 8'hA5);
      chk("ss_sample_cnt", sample_cnt, 1);
      chk("ss_idle", busy, 0);
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      chk("ss_empty_after_pop", fifo_empty, 1);
      chk("ss_rd_after_pop", rd_data, 8'hA5);

      // Continuous mode, no reads: fill, then overflow
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      set_adc(8'h00);
      enable = 1'b1;
      n = 0;
      while (!fifo_full && n < 600) begin
         @(negedge clock);
         n++;
      end
      chk("ov_full_reached", (n < 600), 1);
      chk("ov_not_yet", overflow, 0);
      chk("ov_cnt_at_full", sample_cnt, 8);
      chk("ov_head", rd_data, 8'h00);
      n = 0;
      while (!overflow && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("ov_set", overflow, 1);
      chk("ov_full", fifo_full, 1);
      chk("ov_sample_cnt", sample_cnt, 8);
      clear_err = 1'b1;
      @(negedge clock);
      clear_err = 1'b0;
      chk("ov_cleared", overflow, 0);

      // Full FIFO with a pop during CAPTURE: read and write both proceed
      n = 0;
      while (adc_if.nEndCnv !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      while (adc_if.nEndCnv !== 1'b0 && n < 160) begin
         @(negedge clock);
         n++;
      end
      chk("fr_conv_seen", (n < 160), 1);
      @(negedge clock);
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      enable = 1'b0;
      chk("fr_full", fifo_full, 1);
      chk("fr_overflow", overflow, 0);
      chk("fr_sample_cnt", sample_cnt, 9);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_%0d", i), rd_data, exp_drain[i]);
         rd_en = 1'b1;
         @(negedge clock);
         rd_en = 1'b0;
      end
      chk("drain_empty", fifo_empty, 1);

      // Reset while in START releases the start request on the next edge
      adc_dead = 1'b1;
      single = 1'b1;
      @(negedge clock);
      single = 1'b0;
      repeat (2) @(negedge clock);
      chk("rs_start_low", adc_if.nStartCnv, 0);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      chk("rs_nstart", adc_if.nStartCnv, 1);

      // ADC never answers: timeout after 64 cycles in START
      @(negedge clock);
      single = 1'b1;
      @(negedge clock);
      single = 1'b0;
      chk("to_start_low", adc_if.nStartCnv, 0);
      repeat (63) @(negedge clock);
      chk("to_not_yet", timeout_err, 0);
      chk("to_still_low", adc_if.nStartCnv, 0);
      @(negedge clock);
      chk("to_set", timeout_err, 1);
      chk("to_nstart", adc_if.nStartCnv, 1);
      chk("to_idle", busy, 0);
      chk("to_no_write", fifo_empty, 1);
      clear_err = 1'b1;
      @(negedge clock);
      clear_err = 1'b0;
      chk("to_cleared", timeout_err, 0);

      // enable dropped mid-BUSY: sample still captured, then stay idle
      adc_dead = 1'b0;
      set_adc(8'h3C);
      enable = 1'b1;
      @(negedge clock);
      chk("eb_start_low", adc_if.nStartCnv, 0);
      repeat (10) @(negedge clock);
      enable = 1'b0;
      chk("eb_in_busy", busy, 1);
      n = 0;
      while (fifo_empty && n < 60) begin
         @(negedge clock);
         n++;
      end
      chk("eb_rd_data", rd_data, 8'h3C);
      chk("eb_sample_cnt", sample_cnt, 1);
      nlow = 0;
      repeat (100) begin
         @(negedge clock);
         if (adc_if.nStartCnv !== 1'b1) nlow++;
      end
      chk("eb_no_restart", nlow, 0);
      chk("eb_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
